inst_fifo: RTL
==============

// Module: inst_fifo
// PURPOSE
//  Dual-write/dual-read instruction queue between fetch and the dual-issue decode/issue stage.
//  Fetch pushes 0-2 instructions per cycle; decode pops 0-2 per cycle (master = head, slave = head+1).
//  empty/almost_empty drive slave-issue gating: slave may issue only when neither is set.
//  flush (branch redirect / exception) discards all contents.
// PARAMETERS
//  DEPTH  16  entries; power of two, >=4
//  AW     $clog2(DEPTH)  pointer width (derived, not overridden)
// PORTS
//  clk           in   1   single clock, rising edge
//  resetn        in   1   synchronous, active-low reset
//  flush         in   1   drop all entries at next edge
//  write_en1     in   1   push write_inst1/addr1
//  write_en2     in   1   push write_inst2/addr2; only meaningful with write_en1
//  write_inst1   in   32  instruction word, slot 1 (older)
//  write_addr1   in   32  PC of slot 1
//  write_inst2   in   32  instruction word, slot 2 (younger)
//  write_addr2   in   32  PC of slot 2
//  read_en1      in   1   pop head (master issued)
//  read_en2      in   1   pop head+1 (slave issued); only meaningful with read_en1
//  read_inst1    out  32  head instruction (first-word fall-through)
//  read_addr1    out  32  head PC
//  read_inst2    out  32  head+1 instruction
//  read_addr2    out  32  head+1 PC
//  empty         out  1   count==0
//  almost_empty  out  1   count==1
//  full          out  1   count>DEPTH-2 (fewer than 2 free slots)
// BEHAVIOUR
//  - State: entry array, head ptr, tail ptr (AW bits, wrap mod DEPTH), count (AW+1 bits).
//  - Reset (resetn=0 at edge): head=tail=count=0 -> empty=1, almost_empty=0, full=0; array contents don't-care.
//  - Outputs combinational from registered state, zero latency: read_*1 = entry[head] if count>=1 else 0;
//    read_*2 = entry[head+1] if count>=2 else 0.
//  - Push: full=1 -> both writes dropped (fetch must hold). Else n_w = write_en1 + (write_en1&write_en2);
//    slot1 -> entry[tail], slot2 -> entry[tail+1]; tail += n_w. write_en2 without write_en1 ignored.
//  - Pop: n_r = read_en1&(count>=1) + read_en1&read_en2&(count>=2); head += n_r.
//    Pop while empty, or second pop while almost_empty, silently ignored.
//  - Same-cycle push+pop legal at any count, including full (full gates writes on pre-edge count).
//    count_next = count + n_w - n_r. Pops read pre-edge contents; a push never fills an entry
//    popped in the same cycle (no bypass).
//  - Pointer wrap: DEPTH-1 -> 0; 2-entry push/pop at DEPTH-1 splits across the wrap.
//  - Priority at edge: resetn=0 > flush > push/pop. flush=1: head=tail=count=0; same-cycle pushes/pops discarded.
//  - Invariant: 0<=count<=DEPTH; assertion count never exceeds DEPTH.
// CONFIGURATION
//  INST_FIFO_STATS_EN defined: adds output empty_cycles [31:0]; increments (wrapping) each cycle
//    empty=1 and flush=0; cleared by reset only.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1. Reset: resetn=0 one edge -> empty=1, almost_empty=0, full=0, read_inst1=read_inst2=0.
//  2. Push {0x11,0x22} at PC 0x100/0x104, no pop -> next cycle count=2, read_inst1=0x11, read_inst2=0x22,
//     both flags low; pop 1 -> read_inst1=0x22, almost_empty=1, read_inst2=0.
//  3. Fill DEPTH=16 with 7 dual pushes -> count=14, full=0; one more dual push -> count=16, full=1;
//     further push dropped, count stays 16.
//  4. Wrap: at head=tail=15, count=0, push 2 then pop 2 -> entries at 15 and 0 returned in order,
//     head=tail=1, empty=1.
//  5. Simultaneous: count=1, read_en1=read_en2=1 with dual push 0xAA/0xBB -> old head popped,
//     second pop ignored; next cycle count=2, read_inst1=0xAA.
//  6. Flush with dual push+pop at count=5 -> next cycle count=0, empty=1;
//     INST_FIFO_STATS_EN build: empty_cycles +1 per later idle cycle.

Source files
------------

// File: rtl/inst_fifo.sv
// Dual-push/dual-pop instruction queue between fetch and dual-issue decode.
// Optional INST_FIFO_STATS_EN adds an empty-cycle counter output.
module inst_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
`ifdef INST_FIFO_STATS_EN
    output logic [31:0] empty_cycles,
`endif
    input  logic        flush,
    input  logic        write_en1,
    input  logic        write_en2,
    input  logic [31:0] write_inst1,
    input  logic [31:0] write_addr1,
    input  logic [31:0] write_inst2,
    input  logic [31:0] write_addr2,
    input  logic        read_en1,
    input  logic        read_en2,
    output logic [31:0] read_inst1,
    output logic [31:0] read_addr1,
    output logic [31:0] read_inst2,
    output logic [31:0] read_addr2,
    output logic        empty,
    output logic        almost_empty,
    output logic        full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_inst [DEPTH];
    logic [31:0]   r_addr [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_ge2;
    logic          w_wr1;
    logic          w_wr2;
    logic          w_rd1;
    logic          w_rd2;
    logic [1:0]    w_nw;
    logic [1:0]    w_nr;
    logic [AW-1:0] w_head1;
    logic [AW-1:0] w_tail1;

    assign w_empty = (r_count == '0);
    assign w_ge2   = (r_count > CW'(1));
    assign w_full  = (r_count > CW'(DEPTH - 2));

    // Full is judged on the pre-edge count, so a same-cycle pop never frees room.
    assign w_wr1 = write_en1 & ~w_full;
    assign w_wr2 = w_wr1 & write_en2;
    assign w_rd1 = read_en1 & ~w_empty;
    assign w_rd2 = w_rd1 & read_en2 & w_ge2;

    assign w_nw = {1'b0, w_wr1} + {1'b0, w_wr2};
    assign w_nr = {1'b0, w_rd1} + {1'b0, w_rd2};

    assign w_head1 = r_head + AW'(1);
    assign w_tail1 = r_tail + AW'(1);

    assign empty        = w_empty;
    assign almost_empty = (r_count == CW'(1));
    assign full         = w_full;

    assign read_inst1 = w_empty ? 32'h0 : r_inst[r_head];
    assign read_addr1 = w_empty ? 32'h0 : r_addr[r_head];
    assign read_inst2 = w_ge2 ? r_inst[w_head1] : 32'h0;
    assign read_addr2 = w_ge2 ? r_addr[w_head1] : 32'h0;

    always_ff @(posedge clk) begin
        if (resetn && !flush) begin
            if (w_wr1) begin
                r_inst[r_tail] <= write_inst1;
                r_addr[r_tail] <= write_addr1;
            end
            if (w_wr2) begin
                r_inst[w_tail1] <= write_inst2;
                r_addr[w_tail1] <= write_addr2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_nr);
            r_tail  <= r_tail + AW'(w_nw);
            r_count <= r_count + CW'(w_nw) - CW'(w_nr);
        end
    end

`ifdef INST_FIFO_STATS_EN
    logic [31:0] r_empty_cycles;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_empty_cycles <= '0;
        end else if (w_empty && !flush) begin
            r_empty_cycles <= r_empty_cycles + 32'd1;
        end
    end

    assign empty_cycles = r_empty_cycles;
`endif

`ifndef SYNTHESIS
    a_count_max: assert property (
        @(posedge clk) disable iff (!resetn) r_count <= CW'(DEPTH)
    );
`endif

endmodule
